// File: rtl/sdram_rw_arbiter_if.sv
// Burst port between the arbiter (master) and the avmm_sdram_wrapper (slave).
// Start pulses, address and count go out. Done, beat handshakes and read data come back.
interface sdram_rw_arbiter_if #(
  parameter int SDRAM_DATA_W = 128,
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 11
);
  logic [ADDR_W-1:0]       rw_addr;
  logic [CNT_W-1:0]        rw_cnt;
  logic                    read_start;
  logic                    write_start;
  logic                    rw_done;
  logic                    read_valid;
  logic [SDRAM_DATA_W-1:0] read_data;
  logic                    write_nxt;
  logic [SDRAM_DATA_W-1:0] write_data;

  modport master (
    output rw_addr, rw_cnt, read_start, write_start, write_data,
    input  rw_done, read_valid, read_data, write_nxt
  );

  modport slave (
    input  rw_addr, rw_cnt, read_start, write_start, write_data,
    output rw_done, read_valid, read_data, write_nxt
  );
endinterface

// File: rtl/sdram_rw_arbiter.sv
// Round-robin arbiter that serialises whole SDRAM burst transactions from NUM_REQ requesters.
// It routes per-beat handshakes to the current owner and flags beat-count violations.
module sdram_rw_arbiter #(
  parameter int SDRAM_DATA_W = 128,
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 11,
  parameter int NUM_REQ      = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]        req_addr,
  input  logic [NUM_REQ*CNT_W-1:0]         req_cnt,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [NUM_REQ-1:0]               req_read_valid,
  output logic [SDRAM_DATA_W-1:0]          req_read_data,
  output logic [NUM_REQ-1:0]               req_write_nxt,
  input  logic [NUM_REQ*SDRAM_DATA_W-1:0]  req_write_data,
  sdram_rw_arbiter_if.master               mem,
  output logic                             busy,
  output logic                             err_beats
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [OW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t         state;
  idx_t           owner;
  idx_t           last_owner;
  logic           is_write;
  logic [CNT_W:0] beat_cnt;

  logic              found;
  idx_t              pick;
  idx_t              cand;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [CNT_W-1:0]  sel_cnt;

  logic           in_busy;
  logic           beat;
  logic [CNT_W:0] beat_total;
  logic           over_beat;
  logic           bad_done;
  logic           stray;
  logic           zero_done;
  logic           burst_end;

  // Scan from last_owner+1 upward; iterating downward lets the nearest candidate win.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = idx_t'((int'(last_owner) + i) % NUM_REQ);
      if (req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_cnt   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == idx_t'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_cnt   = req_cnt[i*CNT_W +: CNT_W];
      end
    end
  end

  assign in_busy    = (state == BUSY);
  assign beat       = in_busy && (is_write ? mem.write_nxt : mem.read_valid);
  assign beat_total = beat_cnt + {{CNT_W{1'b0}}, beat};
  assign over_beat  = beat && (beat_cnt >= {1'b0, mem.rw_cnt});
  assign bad_done   = in_busy && mem.rw_done && (beat_total != {1'b0, mem.rw_cnt});
  assign stray      = !in_busy && (mem.read_valid || mem.write_nxt || mem.rw_done);
  assign zero_done  = (state == ISSUE) && (mem.rw_cnt == '0);
  assign burst_end  = zero_done || (in_busy && mem.rw_done);

  // req_grant is one-hot on the owner whenever not IDLE, so it doubles as the routing mask.
  assign req_done       = burst_end ? req_grant : '0;
  assign req_read_valid = (in_busy && mem.read_valid) ? req_grant : '0;
  assign req_write_nxt  = (in_busy && mem.write_nxt) ? req_grant : '0;
  assign req_read_data  = mem.read_data;
  assign busy           = (state != IDLE);

  always_comb begin
    mem.write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (in_busy && req_grant[i]) begin
        mem.write_data = req_write_data[i*SDRAM_DATA_W +: SDRAM_DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      owner           <= '0;
      last_owner      <= idx_t'(NUM_REQ - 1);
      is_write        <= 1'b0;
      beat_cnt        <= '0;
      req_grant       <= '0;
      mem.read_start  <= 1'b0;
      mem.write_start <= 1'b0;
      mem.rw_addr     <= '0;
      mem.rw_cnt      <= '0;
      err_beats       <= 1'b0;
    end else begin
      mem.read_start  <= 1'b0;
      mem.write_start <= 1'b0;
      if (over_beat || bad_done || stray) begin
        err_beats <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (found) begin
            owner           <= pick;
            is_write        <= sel_write;
            mem.rw_addr     <= sel_addr;
            mem.rw_cnt      <= sel_cnt;
            req_grant       <= NUM_REQ'(1) << pick;
            mem.read_start  <= !sel_write && (sel_cnt != '0);
            mem.write_start <= sel_write && (sel_cnt != '0);
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          beat_cnt <= '0;
          // A zero-length burst still counts as a turn so round-robin keeps rotating.
          if (zero_done) begin
            last_owner <= owner;
            req_grant  <= '0;
            state      <= IDLE;
          end else begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (beat && (beat_cnt != '1)) begin
            beat_cnt <= beat_total;
          end
          if (mem.rw_done) begin
            last_owner <= owner;
            req_grant  <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Bench for sdram_rw_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of ownership, beats and errors.
module tb_sdram_rw_arbiter;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int CW = 11;
  localparam int NR = 3;
  localparam int IW = $clog2(NR);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req_valid, req_write, req_grant, req_done;
  logic [NR-1:0]          req_read_valid, req_write_nxt;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][CW-1:0]  req_cnt;
  logic [NR-1:0][DW-1:0]  req_write_data;
  logic [DW-1:0]          req_read_data;
  logic                   busy, err_beats;

  sdram_rw_arbiter_if #(.SDRAM_DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) mem ();

  sdram_rw_arbiter #(.SDRAM_DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_cnt(req_cnt),
    .req_grant(req_grant), .req_done(req_done), .req_read_valid(req_read_valid),
    .req_read_data(req_read_data), .req_write_nxt(req_write_nxt),
    .req_write_data(req_write_data), .mem(mem), .busy(busy), .err_beats(err_beats)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  // Reference model: owner index (-1 = free), issue flag, latched burst, beats seen, error.
  int          m_owner = -1;
  int          m_last = NR - 1;
  bit          m_issue = 1'b0;
  bit          m_write = 1'b0;
  bit          m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int          m_cnt = 0;
  int          m_beats = 0;

  logic [NR-1:0] prev_done;
  logic [NR-1:0] mask;
  int  fixed_cnt;
  bit  force_req;
  bit  w_active;
  int  w_left;
  int  cyc;
  int  last_done_cyc;

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand128();
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NR-1:0] expDone();
    if (m_owner < 0) return '0;
    if ((m_issue && m_cnt == 0) || (!m_issue && mem.rw_done)) return NR'(1) << m_owner;
    return '0;
  endfunction

  task automatic modelUpdate();
    bit beat;
    int c;
    if (!rst_n) begin
      m_owner = -1; m_issue = 0; m_last = NR - 1; m_write = 0;
      m_addr = '0; m_cnt = 0; m_beats = 0; m_err = 0;
    end else if (m_owner < 0 || m_issue) begin
      if (mem.read_valid || mem.write_nxt || mem.rw_done) m_err = 1;
      if (m_owner < 0) begin
        for (int k = 1; k <= NR; k++) begin
          c = (m_last + k) % NR;
          if (req_valid[IW'(c)]) begin
            m_owner = c;
            m_write = req_write[IW'(c)];
            m_addr  = req_addr[IW'(c)];
            m_cnt   = int'(req_cnt[IW'(c)]);
            m_issue = 1;
            break;
          end
        end
      end else begin
        m_issue = 0;
        m_beats = 0;
        if (m_cnt == 0) begin
          m_last = m_owner;
          m_owner = -1;
        end
      end
    end else begin
      beat = m_write ? mem.write_nxt : mem.read_valid;
      if (beat) begin
        if (m_beats >= m_cnt) m_err = 1;
        m_beats++;
      end
      if (mem.rw_done) begin
        if (m_beats != m_cnt) m_err = 1;
        m_last = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    prev_done = expDone();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic checkOutput();
    logic [NR-1:0] own, e_done, e_rv, e_wn;
    logic [DW-1:0] e_wd;
    bit in_busy;
    own     = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
    in_busy = (m_owner >= 0) && !m_issue;
    e_done  = expDone();
    e_rv    = (in_busy && mem.read_valid) ? own : '0;
    e_wn    = (in_busy && mem.write_nxt) ? own : '0;
    e_wd    = in_busy ? req_write_data[IW'(m_owner)] : '0;
    cmp("grant", req_grant, own);
    cmp("done", req_done, e_done);
    cmp("read_start", mem.read_start, m_issue && !m_write && m_cnt != 0);
    cmp("write_start", mem.write_start, m_issue && m_write && m_cnt != 0);
    cmp("rw_addr", mem.rw_addr, m_addr);
    cmp("rw_cnt", mem.rw_cnt, CW'(m_cnt));
    cmp("read_valid_route", req_read_valid, e_rv);
    cmp("write_nxt_route", req_write_nxt, e_wn);
    cmp("write_data", mem.write_data, e_wd);
    cmp("read_data", req_read_data, mem.read_data);
    cmp("busy", busy, m_owner >= 0);
    cmp("err_beats", err_beats, m_err);
  endtask

  always @(negedge clk) if (check_en) checkOutput();

  task automatic setReq(input int i, input bit wr, input logic [AW-1:0] addr, input int cnt);
    req_valid[IW'(i)] = 1'b1;
    req_write[IW'(i)] = wr;
    req_addr[IW'(i)]  = addr;
    req_cnt[IW'(i)]   = CW'(cnt);
  endtask

  // One autonomous cycle: requesters follow the drop/raise rule, the wrapper serves the model's owner.
  task automatic applyStimulus();
    for (int i = 0; i < NR; i++) begin
      if (prev_done[IW'(i)]) begin
        req_valid[IW'(i)] = 1'b0;
      end else if (!req_valid[IW'(i)] && mask[IW'(i)] && (force_req || $urandom_range(0, 3) == 0)) begin
        setReq(i, 1'($urandom_range(0, 1)), $urandom, (fixed_cnt >= 0) ? fixed_cnt : int'($urandom_range(0, 6)));
      end
    end
    mem.read_valid = 1'b0;
    mem.write_nxt  = 1'b0;
    mem.rw_done    = 1'b0;
    if (m_owner >= 0 && !m_issue) begin
      if (!w_active) begin
        w_active = 1'b1;
        w_left   = m_cnt;
      end
      if (w_left > 0) begin
        if ($urandom_range(0, 1) == 1) begin
          if (m_write) mem.write_nxt = 1'b1;
          else mem.read_valid = 1'b1;
          w_left--;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        mem.rw_done = 1'b1;
        w_active = 1'b0;
      end
    end
    mem.read_data = rand128();
    for (int i = 0; i < NR; i++) req_write_data[IW'(i)] = rand128();
    #1;
    if (|req_done) last_done_cyc = cyc;
    tick();
    cyc++;
  endtask

  task automatic drain();
    mask = '0;
    force_req = 1'b0;
    for (int n = 0; n < 300 && (m_owner >= 0 || req_valid != '0); n++) applyStimulus();
    mem.read_valid = 1'b0; mem.write_nxt = 1'b0; mem.rw_done = 1'b0;
    cmp("drain_busy", busy, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] wv;
    int ngr;
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_cnt = '0; req_write_data = '0;
    mem.rw_done = 1'b0; mem.read_valid = 1'b0; mem.write_nxt = 1'b0; mem.read_data = '0;
    w_active = 1'b0; w_left = 0; cyc = 0; last_done_cyc = -1; fixed_cnt = -1; force_req = 1'b0; mask = '0;
    tick();
    check_en = 1'b1;
    tick();
    cmp("reset_grant", req_grant, '0);
    cmp("reset_busy", busy, 1'b0);
    cmp("reset_err", err_beats, 1'b0);
    cmp("reset_rw_addr", mem.rw_addr, '0);
    rst_n = 1'b1;

    $display("[TB] single read");
    setReq(0, 1'b0, 32'h3000_0000, 4);
    tick();
    cmp("rd_start", mem.read_start, 1'b1);
    cmp("rd_addr", mem.rw_addr, 32'h3000_0000);
    cmp("rd_cnt", mem.rw_cnt, 4);
    cmp("rd_grant", req_grant, 3'b001);
    tick();
    for (int b = 0; b < 4; b++) begin
      mem.read_valid = 1'b1;
      mem.read_data = rand128();
      #1 cmp("rd_route", req_read_valid, 3'b001);
      tick();
    end
    mem.read_valid = 1'b0;
    mem.rw_done = 1'b1;
    #1 cmp("rd_done", req_done, 3'b001);
    tick();
    mem.rw_done = 1'b0;
    req_valid[0] = 1'b0;
    cmp("rd_err", err_beats, 1'b0);
    cmp("rd_idle", busy, 1'b0);

    $display("[TB] single write");
    setReq(1, 1'b1, $urandom, 3);
    tick();
    cmp("wr_start", mem.write_start, 1'b1);
    cmp("wr_no_rdstart", mem.read_start, 1'b0);
    tick();
    for (int b = 0; b < 3; b++) begin
      wv = rand128();
      req_write_data[1] = wv;
      mem.write_nxt = 1'b1;
      #1 cmp("wr_data", mem.write_data, wv);
      cmp("wr_route", req_write_nxt, 3'b010);
      tick();
    end
    mem.write_nxt = 1'b0;
    mem.rw_done = 1'b1;
    #1 cmp("wr_done", req_done, 3'b010);
    tick();
    mem.rw_done = 1'b0;
    req_valid[1] = 1'b0;

    $display("[TB] contention");
    mask = 3'b011; fixed_cnt = 2; force_req = 1'b1; ngr = 0; last_done_cyc = -1;
    for (int n = 0; n < 300 && ngr < 4; n++) begin
      applyStimulus();
      if (mem.read_start || mem.write_start) begin
        cmp("cont_grant", req_grant, (ngr % 2 == 0) ? 3'b001 : 3'b010);
        if (last_done_cyc >= 0) cmp("cont_gap", cyc - last_done_cyc, 2);
        ngr++;
      end
    end
    cmp("cont_bursts", ngr, 4);
    drain();

    $display("[TB] zero count");
    setReq(0, 1'b0, $urandom, 0);
    tick();
    cmp("zc_start", {mem.read_start, mem.write_start}, 2'b00);
    cmp("zc_done", req_done, 3'b001);
    tick();
    req_valid[0] = 1'b0;
    cmp("zc_idle", busy, 1'b0);

    $display("[TB] protocol error");
    setReq(0, 1'b0, $urandom, 2);
    tick();
    tick();
    for (int b = 0; b < 3; b++) begin
      mem.read_valid = 1'b1;
      tick();
    end
    mem.read_valid = 1'b0;
    mem.rw_done = 1'b1;
    tick();
    mem.rw_done = 1'b0;
    req_valid[0] = 1'b0;
    cmp("perr_set", err_beats, 1'b1);
    repeat (5) tick();
    cmp("perr_sticky", err_beats, 1'b1);
    rst_n = 1'b0;
    tick();
    cmp("perr_clear", err_beats, 1'b0);
    rst_n = 1'b1;

    $display("[TB] mid-burst reset");
    setReq(1, 1'b0, $urandom, 8);
    tick();
    tick();
    for (int b = 0; b < 3; b++) begin
      mem.read_valid = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    tick();
    cmp("mr_busy", busy, 1'b0);
    cmp("mr_grant", req_grant, '0);
    cmp("mr_rw_cnt", mem.rw_cnt, '0);
    cmp("mr_err", err_beats, 1'b0);
    rst_n = 1'b1;
    mem.read_valid = 1'b0;
    req_valid = '0;
    setReq(0, 1'b0, $urandom, 1);
    setReq(1, 1'b1, $urandom, 1);
    tick();
    cmp("mr_regrant", req_grant, 3'b001);
    w_active = 1'b0;
    drain();

    $display("[TB] random traffic");
    mask = '1; fixed_cnt = -1; force_req = 1'b0;
    repeat (1500) applyStimulus();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_rw_arbiter.md
# sdram_rw_arbiter

Round-robin arbiter sharing the single bi-directional SDRAM port of the `avmm_sdram_wrapper` (rw_addr/rw_cnt/rw_done, read_start/read_valid/read_data, write_start/write_nxt/write_data) between NUM_REQ requesters inside `design_top`. Typical requesters are the activation loader (reads) and the result writer (writes).
- Serialises whole burst transactions.
- Routes the per-beat handshakes to the current owner.
- Flags beat-count protocol violations.

## Interface
Parameters:
- SDRAM_DATA_W, 128, data beat width
- ADDR_W, 32, byte address width
- CNT_W, 11, beat count width (matches Avalon burstcount)
- NUM_REQ, 2, number of requesters (2..8)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- req_valid  in  NUM_REQ  level request, held until matching req_done
- req_write  in  NUM_REQ  1 = write burst, 0 = read burst
- req_addr  in  NUM_REQ*ADDR_W  burst start address, stable while req_valid
- req_cnt  in  NUM_REQ*CNT_W  burst beats, stable while req_valid
- req_grant  out  NUM_REQ  one-hot owner, registered
- req_done  out  NUM_REQ  one-cycle completion pulse
- req_read_valid  out  NUM_REQ  read_valid routed to owner
- req_read_data  out  SDRAM_DATA_W  read_data broadcast to all requesters
- req_write_nxt  out  NUM_REQ  write_nxt routed to owner
- req_write_data  in  NUM_REQ*SDRAM_DATA_W  per-requester write beat
- rw_addr  out  ADDR_W  registered burst address to wrapper
- rw_cnt  out  CNT_W  registered burst count to wrapper
- read_start  out  1  one-cycle read launch
- write_start  out  1  one-cycle write launch
- rw_done  in  1  wrapper burst-complete pulse
- read_valid  in  1  read beat valid
- read_data  in  SDRAM_DATA_W  read beat
- write_nxt  in  1  wrapper consumes write_data this cycle
- write_data  out  SDRAM_DATA_W  muxed owner write beat
- busy  out  1  state != IDLE
- err_beats  out  1  sticky beat-count violation

## Operation
FSM states: IDLE, ISSUE, BUSY.

- **IDLE:** if any req_valid, select the first set bit scanning from (last_owner+1) mod NUM_REQ, wrapping.
  - Latch owner index, req_write, req_addr and req_cnt into rw_addr/rw_cnt.
  - Set req_grant, then go to ISSUE.
  - last_owner resets to NUM_REQ-1, so requester 0 wins first.
- **ISSUE (one cycle):**
  - If latched cnt == 0: no start pulse; pulse req_done[owner]; go to IDLE.
  - Otherwise: read_start or write_start = 1 for this cycle only; clear beat counter; go to BUSY.
- **BUSY:**
  - req_read_valid[owner] = read_valid; req_write_nxt[owner] = write_nxt. Both are combinational; non-owners see 0.
  - write_data = req_write_data slice of owner (combinational mux).
  - Beat counter increments on read_valid (read burst) or write_nxt (write burst).
- **rw_done in BUSY:**
  - req_done[owner] = 1 combinationally in the same cycle.
  - Update last_owner; next state IDLE; req_grant clears on the following edge.
- **err_beats** sets and stays set until reset if any of:
  - beat counter reaches rw_cnt and another beat arrives;
  - rw_done arrives with beat count != rw_cnt;
  - read_valid/write_nxt/rw_done arrives in IDLE or ISSUE.
- rw_done, read_valid and write_nxt outside BUSY are otherwise ignored.
- Requester rule: drop req_valid on the edge after req_done. The arbiter samples req_valid only in IDLE.

## Timing
- Reset values:
  - state IDLE; req_grant 0; req_done 0; read_start 0; write_start 0; rw_addr 0; rw_cnt 0; busy 0; err_beats 0; beat counter 0.
  - req_read_valid, req_write_nxt and write_data are 0 (owner index reset value is irrelevant in IDLE).
- Cycle sequence: req_valid seen in IDLE at cycle T → req_grant and start pulse at T+1 (ISSUE) → BUSY from T+2.
- Back-to-back: rw_done at cycle D → IDLE at D+1 → next grant/start at D+2.
- Minimum inter-burst gap is two cycles.
- Simultaneous requests in IDLE: round-robin choice only; no starvation, and each requester waits at most NUM_REQ-1 bursts.
- Request raised during BUSY waits; it is never preempted.
- rst_n low mid-burst: synchronous return to reset values at the next edge.
  - The wrapper must be reset by the same rst_n.
  - In-flight beats are dropped without setting err_beats.
- Beat counter is CNT_W+1 bits, so a count of 2^CNT_W-1 cannot overflow.

## Test plan
- **Single read:** req 0 read, addr 0x3000_0000, cnt 4.
  - read_start at T+1, rw_addr 0x3000_0000, rw_cnt 4.
  - 4 beats on req_read_valid[0] only; req_done[0] with rw_done; err_beats 0.
- **Single write:** req 1 write, cnt 3, distinct data per beat.
  - write_start pulse; write_data follows req_write_data[1] on every write_nxt; req_done[1] on rw_done.
- **Contention:** req 0 and req 1 both high from reset, each cnt 2, re-requesting after each done.
  - Grants alternate 0,1,0,1; inter-burst start spacing ≥ 2 cycles after rw_done.
- **Zero count:** req 0, cnt 0.
  - No read_start/write_start; req_done[0] at T+1; IDLE at T+2.
- **Protocol error:** cnt 2, wrapper delivers 3 read_valid before rw_done.
  - err_beats = 1 and stays 1 after completion until rst_n.
- **Mid-burst reset:** rst_n low during BUSY of a cnt-8 read.
  - All outputs at reset values on the next edge; a new request afterwards grants requester 0.
